// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: clears the register file after reset, then shares its write port and
// read port 2 between CPU writeback and a debug requester, with a starvation limit.
module rf_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_REG      = 4,
  parameter int AW           = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_waddr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  input  logic [AW-1:0]        cpu_raddr2,
  output logic                 cpu_stall,
  input  logic                 dbg_req,
  input  logic                 dbg_wr,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [WORD_SIZE-1:0] dbg_wdata,
  output logic                 dbg_ack,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output logic                 rf_write,
  output logic [AW-1:0]        rf_addr3,
  output logic [WORD_SIZE-1:0] rf_data3,
  output logic [AW-1:0]        rf_addr2,
  input  logic [WORD_SIZE-1:0] rf_data2
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {INIT, RUN, DBG} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_idx;
  logic [CW-1:0] wait_cnt, wait_n;
  logic served, pend, starved;
  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    served   = 1'b0;
    rf_write = 1'b0;
    rf_addr3 = '0;
    rf_data3 = '0;
    rf_addr2 = state == DBG ? dbg_addr : cpu_raddr2;
    // the ack cycle masks the still-held request so it is not served twice
    pend     = dbg_req && !dbg_ack;
    starved  = wait_cnt == CW'(STARVE_LIMIT - 1);
    case (state)
      INIT: begin
        rf_write = 1'b1;
        rf_addr3 = clr_idx;
        state_n  = clr_idx == AW'(NUM_REG - 1) ? RUN : INIT;
      end
      RUN: begin
        if (cpu_we) begin
          rf_write = 1'b1;
          rf_addr3 = cpu_waddr;
          rf_data3 = cpu_wdata;
        end else if (pend && dbg_wr) begin
          rf_write = 1'b1;
          rf_addr3 = dbg_addr;
          rf_data3 = dbg_wdata;
          served   = 1'b1;
          wait_n   = '0;
        end
        if (pend && (!dbg_wr || (cpu_we && starved))) state_n = DBG;
        else if (pend && cpu_we) wait_n = wait_cnt + 1'b1;
      end
      DBG: begin
        rf_write = dbg_wr;
        rf_addr3 = dbg_wr ? dbg_addr : '0;
        rf_data3 = dbg_wr ? dbg_wdata : '0;
        served   = 1'b1;
        wait_n   = '0;
        state_n  = RUN;
      end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      clr_idx   <= '0;
      wait_cnt  <= '0;
      cpu_stall <= 1'b1;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state     <= state_n;
      clr_idx   <= state == INIT ? clr_idx + 1'b1 : '0;
      wait_cnt  <= wait_n;
      cpu_stall <= state_n != RUN;
      dbg_ack   <= served;
      if (state == DBG && !dbg_wr) dbg_rdata <= rf_data2;
    end
  end
endmodule
